// File: rtl/cordic_result_buffer.sv
// Gain-compensates CORDIC rotation results (x * 1/K in Q4.8) and buffers them in a FWFT FIFO.
// Latency: 2 cycles input to out_valid. No input backpressure: results are dropped and counted when full.
module cordic_result_buffer #(
    parameter int ID_WIDTH = 8,
    parameter int DEPTH    = 8,
    parameter int GAIN_Q08 = 155,
    parameter int AF_GAP   = 3
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic signed [11:0]         in_x,
    input  logic signed [11:0]         in_y,
    input  logic        [ID_WIDTH-1:0] in_id,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [11:0]         out_x,
    output logic signed [11:0]         out_y,
    output logic        [ID_WIDTH-1:0] out_id,
    output logic                       almost_full,
    output logic                       overflow,
    output logic        [7:0]          drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Round-half-up via +128 before the arithmetic shift; |result| <= 1240 so the truncation is lossless.
    function automatic logic signed [11:0] gain_comp(input logic signed [11:0] v);
        logic signed [20:0] prod;
        prod = 21'(v) * $signed(21'(GAIN_Q08)) + 21'sd128;
        return 12'(prod >>> 8);
    endfunction

    logic                       c_vld_q;
    logic signed [11:0]         c_x_q;
    logic signed [11:0]         c_y_q;
    logic        [ID_WIDTH-1:0] c_id_q;

    logic signed [11:0]         mem_x_q  [DEPTH];
    logic signed [11:0]         mem_y_q  [DEPTH];
    logic        [ID_WIDTH-1:0] mem_id_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_q, drop_d;

    logic pop, push, full, drop;

    always_comb begin
        full = (count_q == DEPTH_C);
        pop  = (count_q != '0) && out_ready;
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push = c_vld_q && (!full || pop);
        drop = c_vld_q && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        ovf_d  = ovf_q | drop;
        drop_d = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            c_vld_q  <= 1'b0;
            c_x_q    <= '0;
            c_y_q    <= '0;
            c_id_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_x_q[i]  <= '0;
                mem_y_q[i]  <= '0;
                mem_id_q[i] <= '0;
            end
        end else begin
            c_vld_q  <= in_valid;
            c_x_q    <= gain_comp(in_x);
            c_y_q    <= gain_comp(in_y);
            c_id_q   <= in_id;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            if (push) begin
                mem_x_q[wr_ptr_q]  <= c_x_q;
                mem_y_q[wr_ptr_q]  <= c_y_q;
                mem_id_q[wr_ptr_q] <= c_id_q;
            end
        end
    end

    assign out_valid   = (count_q != '0);
    assign out_x       = mem_x_q[rd_ptr_q];
    assign out_y       = mem_y_q[rd_ptr_q];
    assign out_id      = mem_id_q[rd_ptr_q];
    assign almost_full = (DEPTH - int'(count_q)) <= AF_GAP;
    assign overflow    = ovf_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_cordic_result_buffer.sv
// Randomized and directed bench for cordic_result_buffer against a queue-based reference model.
module tb_cordic_result_buffer;

    localparam int DEPTH  = 8;
    localparam int AF_GAP = 3;
    localparam int GAIN   = 155;

    logic               clock;
    logic               reset_n;
    logic               in_valid;
    logic signed [11:0] in_x;
    logic signed [11:0] in_y;
    logic        [7:0]  in_id;
    logic               out_valid;
    logic               out_ready;
    logic signed [11:0] out_x;
    logic signed [11:0] out_y;
    logic        [7:0]  out_id;
    logic               almost_full;
    logic               overflow;
    logic        [7:0]  drop_count;

    cordic_result_buffer #(
        .ID_WIDTH(8), .DEPTH(DEPTH), .GAIN_Q08(GAIN), .AF_GAP(AF_GAP)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_id       (in_id),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_id      (out_id),
        .almost_full (almost_full),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a staged result plus a bounded queue.
    typedef struct {
        int x;
        int y;
        int id;
    } res_t;

    res_t mq[$];
    bit   mc_vld;
    res_t mc_item;
    bit   m_ovf;
    int   m_drops;

    function automatic int comp(input int v);
        real r;
        r = (real'(v) * real'(GAIN) + 128.0) / 256.0;
        return int'($floor(r));
    endfunction

    task automatic model_clear();
        mq.delete();
        mc_vld  = 1'b0;
        mc_item = '{0, 0, 0};
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic model_edge();
        if (!reset_n) begin
            model_clear();
            return;
        end
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        if (mc_vld) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(mc_item);
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
        mc_vld  = in_valid;
        mc_item = '{comp(int'(in_x)), comp(int'(in_y)), int'(in_id)};
    endtask

    task automatic compare_all();
        check("out_valid", int'(out_valid), int'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("out_x", int'(out_x), mq[0].x);
            check("out_y", int'(out_y), mq[0].y);
            check("out_id", int'(out_id), mq[0].id);
        end
        check("almost_full", int'(almost_full), int'((DEPTH - mq.size()) <= AF_GAP));
        check("overflow", int'(overflow), int'(m_ovf));
        check("drop_count", int'(drop_count), m_drops);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit v, input int x, input int y, input int id, input bit rdy);
        in_valid  = v;
        in_x      = 12'(x);
        in_y      = 12'(y);
        in_id     = 8'(id);
        out_ready = rdy;
    endtask

    function automatic int rnd12();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
        $fatal(1);
    end

    initial begin
        model_clear();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);

        // Reset held with toggling inputs: everything stays zero.
        for (int i = 0; i < 4; i++) begin
            drive(1, rnd12(), rnd12(), int'($urandom_range(0, 255)), 1);
            cycle();
            check("rst_out_x", int'(out_x), 0);
        end
        drive(0, 0, 0, 0, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        check("idle_out_valid", int'(out_valid), 0);

        // Single result, 2-cycle latency, valid for exactly one cycle.
        drive(1, 421, -421, 'h5A, 1);
        cycle();
        check("single_lat1_valid", int'(out_valid), 0);
        drive(0, 0, 0, 0, 1);
        cycle();
        check("single_valid", int'(out_valid), 1);
        check("single_x", int'(out_x), 255);
        check("single_y", int'(out_y), -255);
        check("single_id", int'(out_id), 'h5A);
        cycle();
        check("single_gone", int'(out_valid), 0);

        // Extreme inputs.
        drive(1, -2048, 2047, 'hC3, 1);
        cycle();
        drive(0, 0, 0, 0, 1);
        cycle();
        check("ext_x", int'(out_x), -1240);
        check("ext_y", int'(out_y), 1239);
        cycle();

        // Backpressure fill and overflow.
        for (int i = 0; i < 8; i++) begin
            drive(1, rnd12(), rnd12(), i, 0);
            cycle();
            check("fill_head_id", int'(out_id), 0);
        end
        drive(1, rnd12(), rnd12(), 8, 0);
        cycle();
        check("full_af", int'(almost_full), 1);
        drive(1, rnd12(), rnd12(), 9, 0);
        cycle();
        drive(0, 0, 0, 0, 0);
        cycle();
        check("bp_overflow", int'(overflow), 1);
        check("bp_drops", int'(drop_count), 2);
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            check("drain_id", int'(out_id), i);
            cycle();
        end
        check("drain_empty", int'(out_valid), 0);

        // Full FIFO with continuous push and pop: no drops.
        for (int i = 0; i < 9; i++) begin
            drive(1, rnd12(), rnd12(), 'h10 + i, 0);
            cycle();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, rnd12(), rnd12(), 'h20 + i, 1);
            cycle();
            check("pp_valid", int'(out_valid), 1);
            check("pp_drops", int'(drop_count), 2);
        end
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cycle();

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 5; i++) begin
            drive(1, rnd12(), rnd12(), 'h30 + i, 0);
            cycle();
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        check("arst_valid", int'(out_valid), 0);
        check("arst_x", int'(out_x), 0);
        check("arst_id", int'(out_id), 0);
        check("arst_ovf", int'(overflow), 0);
        check("arst_drops", int'(drop_count), 0);
        check("arst_af", int'(almost_full), 0);
        drive(0, 0, 0, 0, 1);
        cycle();
        cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Randomized traffic with varying ready/valid densities.
        for (int seg = 0; seg < 6; seg++) begin
            int pv;
            int pr;
            pv = int'($urandom_range(20, 100));
            pr = int'($urandom_range(5, 100));
            for (int i = 0; i < 150; i++) begin
                drive(int'($urandom_range(1, 100)) <= pv, rnd12(), rnd12(),
                      int'($urandom_range(0, 255)), int'($urandom_range(1, 100)) <= pr);
                cycle();
            end
        end
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 12; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
